// File: rtl/p2_action_arbiter.sv
// Purpose : player-2 action sequencer; grants one of punch/kick/jump/crouch at a time, owns hit-stun and idle walk.
// Latency : grant and abort one clk after the triggering input; all outputs registered.
// Backpr. : none; button edges seen outside IDLE are dropped (or held in a one-entry buffer).
//
// Ports:
//   clk, Reset (async, active-high)
//   frame_tick                          - one-clk pulse per video frame, timebase for every duration
//   punch_req/kick_req/jump_req         - button levels, rising edge requests the action
//   crouch_req, walk_l, walk_r          - levels
//   hit_in                              - one-clk pulse, preempts everything
//   punch_go/kick_go/jump_go/abort      - one-clk pulses to the motion controllers
//   crouch, busy, walk_x_motion[9:0], state_o[2:0]
// Build option: define INPUT_BUFFER_EN to keep the best edge seen during an action/cooldown
// and grant it on the clk the FSM would return to IDLE.
module p2_action_arbiter #(
  parameter int PUNCH_FRAMES    = 6,
  parameter int KICK_FRAMES     = 8,
  parameter int JUMP_FRAMES     = 16,
  parameter int HITSTUN_FRAMES  = 12,
  parameter int COOLDOWN_FRAMES = 3,
  parameter int WALK_SPEED      = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       punch_req,
  input  logic       kick_req,
  input  logic       jump_req,
  input  logic       crouch_req,
  input  logic       walk_l,
  input  logic       walk_r,
  input  logic       hit_in,
  output logic       punch_go,
  output logic       kick_go,
  output logic       jump_go,
  output logic       abort,
  output logic       crouch,
  output logic       busy,
  output logic [9:0] walk_x_motion,
  output logic [2:0] state_o
);

  localparam int CW = 8;
  localparam logic signed [9:0] WALK_V = 10'(WALK_SPEED);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUNCH    = 3'd1,
    S_KICK     = 3'd2,
    S_JUMP     = 3'd3,
    S_CROUCH   = 3'd4,
    S_HITSTUN  = 3'd5,
    S_COOLDOWN = 3'd6
  } state_t;

  // Numeric order equals priority, and each code equals its action state's encoding.
  typedef enum logic [1:0] {
    A_NONE  = 2'd0,
    A_PUNCH = 2'd1,
    A_KICK  = 2'd2,
    A_JUMP  = 2'd3
  } act_t;

  function automatic logic [CW-1:0] act_frames(input act_t a);
    case (a)
      A_PUNCH: return CW'(PUNCH_FRAMES);
      A_KICK:  return CW'(KICK_FRAMES);
      A_JUMP:  return CW'(JUMP_FRAMES);
      default: return '0;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           btn_q, rise;
  act_t                 best, grant;
  logic                 abort_d, hold_done, to_idle;
  logic signed [9:0]    walk_d;
`ifdef INPUT_BUFFER_EN
  act_t                 buf_q, buf_d;
`endif

  always_comb begin
    // Pending requests are the current-clk rising edges: a request is granted on the
    // very clk its edge is seen, so nothing needs to persist in IDLE.
    rise = {jump_req, kick_req, punch_req} & ~btn_q;
    if (rise[2])      best = A_JUMP;
    else if (rise[1]) best = A_KICK;
    else if (rise[0]) best = A_PUNCH;
    else              best = A_NONE;

    state_d   = state_q;
    cnt_d     = cnt_q;
    grant     = A_NONE;
    abort_d   = 1'b0;
    to_idle   = 1'b0;
    // The tick that takes the count to zero ends the phase.
    hold_done = frame_tick && (cnt_q <= CW'(1));
`ifdef INPUT_BUFFER_EN
    buf_d = buf_q;
`endif

    if (hit_in) begin
      state_d = S_HITSTUN;
      cnt_d   = CW'(HITSTUN_FRAMES);
      abort_d = 1'b1;
`ifdef INPUT_BUFFER_EN
      buf_d = A_NONE;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (best != A_NONE) begin
            grant = best;
          end else if (crouch_req) begin
            state_d = S_CROUCH;
`ifdef INPUT_BUFFER_EN
            buf_d = A_NONE;
`endif
          end
        end
        S_PUNCH, S_KICK, S_JUMP: begin
`ifdef INPUT_BUFFER_EN
          if (best > buf_d) buf_d = best;
`endif
          if (frame_tick) cnt_d = cnt_q - CW'(1);
          if (hold_done) begin
            if (COOLDOWN_FRAMES > 0) begin
              state_d = S_COOLDOWN;
              cnt_d   = CW'(COOLDOWN_FRAMES);
            end else begin
              to_idle = 1'b1;
            end
          end
        end
        S_COOLDOWN: begin
`ifdef INPUT_BUFFER_EN
          if (best > buf_d) buf_d = best;
`endif
          if (frame_tick) cnt_d = cnt_q - CW'(1);
          if (hold_done) to_idle = 1'b1;
        end
        S_CROUCH: begin
          if (!crouch_req) state_d = S_IDLE;
        end
        S_HITSTUN: begin
          if (frame_tick) cnt_d = cnt_q - CW'(1);
          if (hold_done) to_idle = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase

      if (to_idle) begin
        state_d = S_IDLE;
        cnt_d   = '0;
`ifdef INPUT_BUFFER_EN
        // A buffered request skips the idle clk and starts right away.
        if (buf_d != A_NONE) begin
          grant = buf_d;
          buf_d = A_NONE;
        end
`endif
      end

      if (grant != A_NONE) begin
        state_d = state_t'({1'b0, grant});
        cnt_d   = act_frames(grant);
      end
    end

    walk_d = '0;
    if (state_d == S_IDLE && !crouch_req) begin
      if (walk_r && !walk_l)      walk_d = WALK_V;
      else if (walk_l && !walk_r) walk_d = -WALK_V;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      btn_q         <= '0;
      punch_go      <= 1'b0;
      kick_go       <= 1'b0;
      jump_go       <= 1'b0;
      abort         <= 1'b0;
      crouch        <= 1'b0;
      busy          <= 1'b0;
      walk_x_motion <= '0;
`ifdef INPUT_BUFFER_EN
      buf_q         <= A_NONE;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_q         <= {jump_req, kick_req, punch_req};
      punch_go      <= (grant == A_PUNCH);
      kick_go       <= (grant == A_KICK);
      jump_go       <= (grant == A_JUMP);
      abort         <= abort_d;
      crouch        <= (state_d == S_CROUCH);
      busy          <= (state_d != S_IDLE);
      walk_x_motion <= walk_d;
`ifdef INPUT_BUFFER_EN
      buf_q         <= buf_d;
`endif
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_p2_action_arbiter.sv
// Purpose : self-checking bench for p2_action_arbiter against a frame-count reference model.
// Latency : model outputs describe the clk edge following each applied input vector.
// Backpr. : n/a.
module tb_p2_action_arbiter;

  localparam int COOL = 3;
  localparam int HITS = 12;
  localparam int SPD  = 2;

  logic       clk = 1'b0;
  logic       Reset;
  logic       frame_tick, punch_req, kick_req, jump_req, crouch_req;
  logic       walk_l, walk_r, hit_in;
  logic       punch_go, kick_go, jump_go, abort, crouch, busy;
  logic [9:0] walk_x_motion;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  p2_action_arbiter dut (
    .clk(clk), .Reset(Reset), .frame_tick(frame_tick),
    .punch_req(punch_req), .kick_req(kick_req), .jump_req(jump_req),
    .crouch_req(crouch_req), .walk_l(walk_l), .walk_r(walk_r), .hit_in(hit_in),
    .punch_go(punch_go), .kick_go(kick_go), .jump_go(jump_go), .abort(abort),
    .crouch(crouch), .busy(busy), .walk_x_motion(walk_x_motion), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Activity: 0 idle, 1 punch, 2 kick, 3 jump, 4 crouch, 5 hitstun, 6 cooldown.
  int         m_act, m_left, m_go, m_abort, m_buf, m_walk;
  logic [2:0] m_prev;
  int         dur[4] = '{0, 6, 8, 16};

  task automatic model_reset();
    m_act = 0; m_left = 0; m_go = 0; m_abort = 0; m_buf = 0; m_walk = 0; m_prev = 3'b000;
  endtask

  task automatic model_start(input int a);
    m_act = a; m_left = dur[a]; m_go = a;
  endtask

  task automatic model_finish();
    m_act = 0;
`ifdef INPUT_BUFFER_EN
    if (m_buf != 0) begin
      model_start(m_buf);
      m_buf = 0;
    end
`endif
  endtask

  task automatic model_step(input logic p, k, j, c, wl, wr, h, t);
    int req;
    req = (j && !m_prev[2]) ? 3 : (k && !m_prev[1]) ? 2 : (p && !m_prev[0]) ? 1 : 0;
    m_go = 0; m_abort = 0;
    if (h) begin
      m_act = 5; m_left = HITS; m_abort = 1; m_buf = 0;
    end else if (m_act == 0) begin
      if (req != 0) model_start(req);
      else if (c) m_act = 4;
    end else if (m_act == 4) begin
      if (!c) m_act = 0;
    end else begin
`ifdef INPUT_BUFFER_EN
      if (m_act != 5 && req > m_buf) m_buf = req;
`endif
      if (t) begin
        m_left = m_left - 1;
        if (m_left <= 0) begin
          if (m_act >= 1 && m_act <= 3 && COOL > 0) begin
            m_act = 6; m_left = COOL;
          end else begin
            model_finish();
          end
        end
      end
    end
    m_walk = 0;
    if (m_act == 0 && !c) m_walk = (wr && !wl) ? SPD : (wl && !wr) ? -SPD : 0;
    m_prev = {j, k, p};
  endtask

  task automatic compare_all(input string tag);
    logic [9:0] ew;
    ew = 10'(m_walk);
    chk({tag, ".state"},  32'(state_o),  32'(m_act));
    chk({tag, ".busy"},   32'(busy),     32'(m_act != 0));
    chk({tag, ".crouch"}, 32'(crouch),   32'(m_act == 4));
    chk({tag, ".pgo"},    32'(punch_go), 32'(m_go == 1));
    chk({tag, ".kgo"},    32'(kick_go),  32'(m_go == 2));
    chk({tag, ".jgo"},    32'(jump_go),  32'(m_go == 3));
    chk({tag, ".abort"},  32'(abort),    32'(m_abort));
    chk({tag, ".walk"},   32'(walk_x_motion), 32'(ew));
  endtask

  // Called at a negedge: apply inputs, advance the model, compare at the next negedge.
  task automatic step(input string tag, input logic p, k, j, c, wl, wr, h, t);
    punch_req = p; kick_req = k; jump_req = j; crouch_req = c;
    walk_l = wl; walk_r = wr; hit_in = h; frame_tick = t;
    model_step(p, k, j, c, wl, wr, h, t);
    @(negedge clk);
    compare_all(tag);
  endtask

  int go_seen;

  initial begin
    Reset = 1'b1;
    {frame_tick, punch_req, kick_req, jump_req, crouch_req, walk_l, walk_r, hit_in} = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("rst");
    Reset = 1'b0;

    // Punch held through the whole action, tick every 4 clks.
    go_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step("punch", 1, 0, 0, 0, 0, 0, 0, (i % 4) == 3);
      go_seen += int'(punch_go);
    end
    chk("punch.single_go", 32'(go_seen), 32'd1);
    step("punch_rel", 0, 0, 0, 0, 0, 0, 0, 0);

    // Async reset in the middle of a punch, with no clk edge.
    step("pre_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    step("pre_rst", 1, 0, 0, 0, 0, 0, 0, 1);
    chk("pre_rst.in_punch", 32'(state_o), 32'd1);
    #2 Reset = 1'b1;
    #1 model_reset();
    compare_all("async_rst");
    @(negedge clk);
    Reset = 1'b0;
    step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst.pgo", 32'(punch_go), 32'd1);
    for (int i = 0; i < 50; i++) step("post_rst", 0, 0, 0, 0, 0, 0, 0, (i % 4) == 0);

    // Punch and jump in the same clk.
    for (int i = 0; i < 90; i++) step("pj", 1, 0, 1, 0, 0, 0, 0, (i % 4) == 2);
    step("pj_rel", 0, 0, 0, 0, 0, 0, 0, 0);

    // Hit during the third tick of a kick.
    for (int i = 0; i < 70; i++)
      step("hit", 0, 1, 0, 0, 0, 0, i == 11, (i % 4) == 3);
    step("hit_rel", 0, 0, 0, 0, 0, 0, 0, 0);

    // Crouch with punch edges, then release.
    for (int i = 0; i < 12; i++) step("crouch", i[1], 0, 0, 1, 0, 1, 0, 0);
    chk("crouch.state", 32'(state_o), 32'd4);
    step("crouch_rel", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("crouch_rel.idle", 32'(state_o), 32'd0);

    // Walking in IDLE.
    step("walk_l", 0, 0, 0, 0, 1, 0, 0, 0);
    chk("walk_l.val", 32'(walk_x_motion), 32'h3FE);
    step("walk_r", 0, 0, 0, 0, 0, 1, 0, 0);
    step("walk_both", 0, 0, 0, 0, 1, 1, 0, 0);

    // Kick edge during COOLDOWN (granted on idle entry only when buffering is built in).
    step("buf", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      step("buf", 1, i == 28, 0, 0, 0, 0, 0, (i % 4) == 3);

    // Randomized traffic.
    begin
      logic p, k, j, c, wl, wr;
      p = 0; k = 0; j = 0; c = 0; wl = 0; wr = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0)  p  = ~p;
        if ($urandom_range(0, 9) == 0)  k  = ~k;
        if ($urandom_range(0, 11) == 0) j  = ~j;
        if ($urandom_range(0, 29) == 0) c  = ~c;
        if ($urandom_range(0, 5) == 0)  wl = ~wl;
        if ($urandom_range(0, 5) == 0)  wr = ~wr;
        step("rand", p, k, j, c, wl, wr, $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p2_action_arbiter.md
Name: p2_action_arbiter

Overview:
Player-2 action sequencer that sits above the per-action motion controllers (punch, kick, jump). It arbitrates the raw button requests and grants exactly one action at a time. It holds the grant for the action's frame duration, enforces a recovery cooldown, and lets a hit preempt any action. It also produces the idle walk motion, so the position logic receives a single coherent command stream.

Parameters:
PUNCH_FRAMES, 6, frame ticks a punch grant is held
KICK_FRAMES, 8, frame ticks a kick grant is held
JUMP_FRAMES, 16, frame ticks a jump grant is held
HITSTUN_FRAMES, 12, frame ticks of hit-stun
COOLDOWN_FRAMES, 3, recovery frame ticks after punch/kick/jump
WALK_SPEED, 2, pixels per frame for idle walking

Ports:
clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-clk pulse per video frame; all durations count these
punch_req  in  1  punch button level
kick_req  in  1  kick button level
jump_req  in  1  jump button level
crouch_req  in  1  crouch button level
walk_l  in  1  walk-left level
walk_r  in  1  walk-right level
hit_in  in  1  one-clk pulse: player 2 was struck
punch_go  out  1  one-clk pulse starting the punch controller
kick_go  out  1  one-clk pulse starting the kick controller
jump_go  out  1  one-clk pulse starting the jump controller
abort  out  1  one-clk pulse: sub-controllers return to rest
crouch  out  1  high while in CROUCH
busy  out  1  high in any state except IDLE
walk_x_motion  out  10  signed walk velocity
state_o  out  3  current state encoding, for debug/sprite select

Behaviour:
- The clock port is clk. Reset is asynchronous and active-high, on port Reset.
- Reset state: state IDLE; frame counter 0; all pending flags 0; all outputs 0.
- States and encodings: IDLE=0, PUNCH=1, KICK=2, JUMP=3, CROUCH=4, HITSTUN=5, COOLDOWN=6.
- Edge detection: punch/kick/jump are registered every clk. A rising edge sets the matching pending flag. Holding a button never retriggers.
- Priority: hit_in > jump > kick > punch > crouch > walk.
- IDLE:
  - If any pending flag is set, grant the highest one: go to that action state, pulse its *_go for exactly one clk, clear all pending flags, and load the counter with the action's FRAMES value.
  - Else if crouch_req, go to CROUCH.
  - Grant latency: one clk from the rising edge, independent of frame_tick.
- PUNCH/KICK/JUMP:
  - Decrement the counter on each frame_tick.
  - On the tick that reaches 0, go to COOLDOWN with counter = COOLDOWN_FRAMES.
  - If COOLDOWN_FRAMES=0, go to IDLE instead.
- COOLDOWN: decrement on frame_tick; at 0, go to IDLE.
- CROUCH:
  - Stay while crouch_req is high.
  - Return to IDLE the clk after crouch_req falls, with no cooldown.
  - punch/kick/jump edges are discarded while crouched.
- HITSTUN:
  - hit_in in any state, including IDLE and HITSTUN, goes to HITSTUN the next clk with counter = HITSTUN_FRAMES, pulses abort for one clk, and clears all pending flags.
  - Decrement on frame_tick; at 0, go to IDLE with no cooldown.
- Edges arriving outside IDLE are discarded (see optional feature).
- Simultaneous events:
  - hit_in in the same clk as a grant: hit wins, no *_go is pulsed.
  - frame_tick in the same clk as the grant: that tick does not decrement the new count.
  - Two rising edges in the same clk: priority decides.
- walk_x_motion:
  - Valid only in IDLE with crouch_req low.
  - walk_r only gives +WALK_SPEED; walk_l only gives -WALK_SPEED; both or neither gives 0.
  - 0 in every other state.
  - Two's complement, sign-extended to 10 bits.
- busy = (state != IDLE). crouch = (state == CROUCH). All outputs are registered.

Optional Feature:
INPUT_BUFFER_EN
- Defined: a one-entry buffer captures the highest-priority punch/kick/jump edge seen during an action state or COOLDOWN. A later higher-priority edge overwrites it; a lower-priority edge does not.
- On the clk the FSM enters IDLE, a valid buffer entry is granted immediately, with *_go pulsed in that same clk, and the buffer is cleared.
- hit_in, CROUCH entry and Reset clear the buffer.
- Undefined: no buffer exists; edges outside IDLE are dropped exactly as described in Behaviour.

Test Plan:
- Reset mid-PUNCH: assert Reset asynchronously with no clk edge → state_o=0, all outputs 0 immediately; after release, a punch edge is granted normally.
- Punch from IDLE with frame_tick every 4 clk → punch_go 1 clk after the edge; busy holds for 6 ticks; 3 ticks of COOLDOWN; IDLE; holding the button produces no second punch_go.
- punch and jump rising in the same clk → only jump_go pulses; state_o=3 for 16 ticks.
- hit_in during tick 3 of KICK → abort pulse, state_o=5 for 12 ticks, then IDLE; kick_go never re-fires.
- crouch_req held with punch edges → state_o=4, no punch_go, walk_x_motion=0; release crouch_req → IDLE the next clk.
- walk_l=1, walk_r=0 in IDLE → walk_x_motion=-2 (10'h3FE); both walk inputs high → 0. With INPUT_BUFFER_EN defined, a kick edge during COOLDOWN → kick_go in the same clk IDLE is entered.
